// File: rtl/if_id_decode_if.sv
// IF/ID decode bus: fetch-side inputs, writeback port, and decoded outputs.
// The master side (fetch/writeback environment) drives the inputs; the
// decode stage is the slave.
interface if_id_decode_if;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        halt;
  logic        stall;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  opcode;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        halt_out;

  modport master (
    output instruction, PC, halt, stall, flush, wb_wen, wb_rd, wb_data,
    input  id_valid, id_pc, id_instr, rs1, rs2, rd, funct3, funct7, opcode,
    input  rs1_data, rs2_data, imm, halt_out
  );

  modport slave (
    input  instruction, PC, halt, stall, flush, wb_wen, wb_rd, wb_data,
    output id_valid, id_pc, id_instr, rs1, rs2, rd, funct3, funct7, opcode,
    output rs1_data, rs2_data, imm, halt_out
  );
endinterface

// File: rtl/if_id_decode.sv
// IF/ID pipeline register, field decode, immediate generation, 32x32
// register file and halt sequencing.
// Optional feature: define ID_BYPASS_EN for same-cycle writeback
// write-through on the register-file read ports.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal capture of fetched instructions
// HALT_PEND | halt instruction sits in IF/ID; a flush can still cancel it
// HALTED    | processor stopped, halt_out=1, only rst leaves this state
module if_id_decode (
  input  logic            clk,
  input  logic            rst,
  if_id_decode_if.slave   bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

  state_t      state;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;
  logic        halt_out_q;
  logic [31:0] regs [32];
  logic [31:0] imm_c;
  logic [31:0] rs1_rd;
  logic [31:0] rs2_rd;

  // IF/ID register and halt FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'd0;
      id_instr_q <= NOP;
      halt_out_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.flush) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
          end else if (!bus.stall) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= bus.PC;
            id_instr_q <= bus.instruction;
            if (bus.halt) state <= HALT_PEND;
          end
        end
        HALT_PEND: begin
          if (bus.flush) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
            state      <= RUN;
          end else if (!bus.stall) begin
            id_valid_q <= 1'b0;
            halt_out_q <= 1'b1;
            state      <= HALTED;
          end
        end
        HALTED: begin
          id_valid_q <= 1'b0;
          halt_out_q <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Register file write port; keeps retiring writebacks in every FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (bus.wb_wen && (bus.wb_rd != 5'd0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_instr = id_instr_q;
  assign bus.halt_out = halt_out_q;

  assign bus.rs1    = id_instr_q[19:15];
  assign bus.rs2    = id_instr_q[24:20];
  assign bus.rd     = id_instr_q[11:7];
  assign bus.funct3 = id_instr_q[14:12];
  assign bus.funct7 = id_instr_q[31:25];
  assign bus.opcode = id_instr_q[6:0];

  // Immediate generation by opcode, sign-extended from bit 31
  always_comb begin
    imm_c = 32'd0;
    case (id_instr_q[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm_c = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
      7'b0100011:
        imm_c = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
      7'b1100011:
        imm_c = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
                 id_instr_q[30:25], id_instr_q[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_c = {id_instr_q[31:12], 12'd0};
      7'b1101111:
        imm_c = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
                 id_instr_q[20], id_instr_q[30:21], 1'b0};
      default: imm_c = 32'd0;
    endcase
  end

  assign bus.imm = imm_c;

  // Asynchronous operand reads; x0 always reads as zero
  always_comb begin
    rs1_rd = regs[id_instr_q[19:15]];
    rs2_rd = regs[id_instr_q[24:20]];
`ifdef ID_BYPASS_EN
    if (bus.wb_wen && (bus.wb_rd == id_instr_q[19:15])) rs1_rd = bus.wb_data;
    if (bus.wb_wen && (bus.wb_rd == id_instr_q[24:20])) rs2_rd = bus.wb_data;
`else
`endif
    if (id_instr_q[19:15] == 5'd0) rs1_rd = 32'd0;
    if (id_instr_q[24:20] == 5'd0) rs2_rd = 32'd0;
  end

  assign bus.rs1_data = rs1_rd;
  assign bus.rs2_data = rs2_rd;

endmodule
